// File: rtl/mcpu_core_pkg.sv
// Shared types and constants for the Moroso CPU core writeback path.
package mcpu_core_pkg;

   localparam int unsigned LANES  = 4;
   localparam int unsigned GPR_W  = 5;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned LANE_W = $clog2(LANES);

   typedef struct packed {
      logic [GPR_W-1:0]  rd_num;
      logic [DATA_W-1:0] rd_data;
   } late_entry_t;

   typedef struct packed {
      logic              rd_we;
      logic              pred_we;
      logic [GPR_W-1:0]  rd_num;
      logic [DATA_W-1:0] rd_data;
   } wb_port_t;

endpackage

// File: rtl/mcpu_core_late_fifo.sv
// Synchronous FIFO holding late load results until a write lane is free.
module mcpu_core_late_fifo
   import mcpu_core_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  late_entry_t                push_data,
   input  logic                       pop,
   output late_entry_t                head,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   late_entry_t    mem [DEPTH];
   logic [AW-1:0]  rd_ptr;
   logic [AW-1:0]  wr_ptr;
   logic           push_ok;
   logic           pop_ok;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mcpu_core_wb_merge.sv
// Writeback merge: registers execute lanes and slots queued load results into free lanes.
module mcpu_core_wb_merge
   import mcpu_core_pkg::*;
#(
   parameter int unsigned LATE_DEPTH = 4
) (
   input  logic                          clkrst_core_clk,
   input  logic                          clkrst_core_rst,
   input  logic [3:0]                    ex2wb_rd_we,
   input  logic [3:0]                    ex2wb_pred_we,
   input  logic [19:0]                   ex2wb_rd_num,
   input  logic [127:0]                  ex2wb_rd_data,
   input  logic                          mem2wb_valid,
   output logic                          mem2wb_ready,
   input  logic [4:0]                    mem2wb_rd_num,
   input  logic [31:0]                   mem2wb_rd_data,
   input  logic                          d2wb_load_issue,
   input  logic [4:0]                    d2wb_load_rd_num,
   output logic [31:0]                   wb2d_pending,
   output logic                          wb2rf_rd_we0,
   output logic                          wb2rf_rd_we1,
   output logic                          wb2rf_rd_we2,
   output logic                          wb2rf_rd_we3,
   output logic                          wb2rf_pred_we0,
   output logic                          wb2rf_pred_we1,
   output logic                          wb2rf_pred_we2,
   output logic                          wb2rf_pred_we3,
   output logic [4:0]                    wb2rf_rd_num0,
   output logic [4:0]                    wb2rf_rd_num1,
   output logic [4:0]                    wb2rf_rd_num2,
   output logic [4:0]                    wb2rf_rd_num3,
   output logic [31:0]                   wb2rf_rd_data0,
   output logic [31:0]                   wb2rf_rd_data1,
   output logic [31:0]                   wb2rf_rd_data2,
   output logic [31:0]                   wb2rf_rd_data3,
   output logic [$clog2(LATE_DEPTH):0]   wb2d_fifo_count
);

   wb_port_t           lane_in  [LANES];
   wb_port_t           lane_nxt [LANES];
   wb_port_t           lane_q   [LANES];
   logic [LANES-1:0]   free;
   logic               any_free;
   logic [LANE_W-1:0]  sel;
   logic               fifo_full;
   logic               fifo_empty;
   logic               push;
   logic               pop;
   late_entry_t        push_data;
   late_entry_t        head;
   logic [31:0]        pending_nxt;

   assign mem2wb_ready = !clkrst_core_rst && !fifo_full;
   assign push         = mem2wb_valid && mem2wb_ready;
   assign push_data    = '{rd_num: mem2wb_rd_num, rd_data: mem2wb_rd_data};
   assign free         = ~(ex2wb_rd_we | ex2wb_pred_we);
   assign pop          = !fifo_empty && any_free;

   mcpu_core_late_fifo #(
      .DEPTH (LATE_DEPTH)
   ) u_late_fifo (
      .clk       (clkrst_core_clk),
      .rst       (clkrst_core_rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (wb2d_fifo_count)
   );

   // Highest free lane wins so a same-cycle execute write in a lower lane overrides the load.
   always_comb begin
      sel      = '0;
      any_free = 1'b0;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (free[i]) begin
            sel      = LANE_W'(i);
            any_free = 1'b1;
         end
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < LANES; i++) begin
         lane_in[i].rd_we   = ex2wb_rd_we[i];
         lane_in[i].pred_we = ex2wb_pred_we[i];
         lane_in[i].rd_num  = ex2wb_rd_num[GPR_W*i +: GPR_W];
         lane_in[i].rd_data = ex2wb_rd_data[DATA_W*i +: DATA_W];
         lane_nxt[i]        = lane_in[i];
         if (pop && (sel == LANE_W'(i))) begin
            lane_nxt[i] = '{rd_we: 1'b1, pred_we: 1'b0,
                            rd_num: head.rd_num, rd_data: head.rd_data};
         end
      end
   end

   always_ff @(posedge clkrst_core_clk) begin
      for (int unsigned i = 0; i < LANES; i++) begin
         if (clkrst_core_rst) lane_q[i] <= '0;
         else                 lane_q[i] <= lane_nxt[i];
      end
   end

   // Set is applied after clear so a new issue wins over a same-cycle retire.
   always_comb begin
      pending_nxt = wb2d_pending;
      if (pop)             pending_nxt[head.rd_num]      = 1'b0;
      if (d2wb_load_issue) pending_nxt[d2wb_load_rd_num] = 1'b1;
   end

   always_ff @(posedge clkrst_core_clk) begin
      if (clkrst_core_rst) wb2d_pending <= '0;
      else                 wb2d_pending <= pending_nxt;
   end

   assign wb2rf_rd_we0   = lane_q[0].rd_we;
   assign wb2rf_rd_we1   = lane_q[1].rd_we;
   assign wb2rf_rd_we2   = lane_q[2].rd_we;
   assign wb2rf_rd_we3   = lane_q[3].rd_we;
   assign wb2rf_pred_we0 = lane_q[0].pred_we;
   assign wb2rf_pred_we1 = lane_q[1].pred_we;
   assign wb2rf_pred_we2 = lane_q[2].pred_we;
   assign wb2rf_pred_we3 = lane_q[3].pred_we;
   assign wb2rf_rd_num0  = lane_q[0].rd_num;
   assign wb2rf_rd_num1  = lane_q[1].rd_num;
   assign wb2rf_rd_num2  = lane_q[2].rd_num;
   assign wb2rf_rd_num3  = lane_q[3].rd_num;
   assign wb2rf_rd_data0 = lane_q[0].rd_data;
   assign wb2rf_rd_data1 = lane_q[1].rd_data;
   assign wb2rf_rd_data2 = lane_q[2].rd_data;
   assign wb2rf_rd_data3 = lane_q[3].rd_data;

endmodule

// File: tb/tb_mcpu_core_wb_merge.sv
// Randomized bench for mcpu_core_wb_merge against a queue-based reference model.
module tb_mcpu_core_wb_merge;

   localparam int D = 4;

   typedef struct {
      logic [4:0]  n;
      logic [31:0] d;
   } ent_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   rd_we, pred_we;
   logic [19:0]  rd_num;
   logic [127:0] rd_data;
   logic         valid;
   logic [4:0]   mnum;
   logic [31:0]  mdata;
   logic         issue;
   logic [4:0]   inum;
   logic         ready;
   logic [31:0]  pending;
   logic [2:0]   cnt;
   logic         o_we  [4];
   logic         o_pwe [4];
   logic [4:0]   o_num [4];
   logic [31:0]  o_data[4];

   ent_t         q[$];
   logic [31:0]  m_pend;
   logic         e_we  [4];
   logic         e_pwe [4];
   logic [4:0]   e_num [4];
   logic [31:0]  e_data[4];
   int           passed = 0;
   int           total  = 0;

   always #5 clk = ~clk;

   mcpu_core_wb_merge #(.LATE_DEPTH(D)) dut (
      .clkrst_core_clk  (clk),
      .clkrst_core_rst  (rst),
      .ex2wb_rd_we      (rd_we),
      .ex2wb_pred_we    (pred_we),
      .ex2wb_rd_num     (rd_num),
      .ex2wb_rd_data    (rd_data),
      .mem2wb_valid     (valid),
      .mem2wb_ready     (ready),
      .mem2wb_rd_num    (mnum),
      .mem2wb_rd_data   (mdata),
      .d2wb_load_issue  (issue),
      .d2wb_load_rd_num (inum),
      .wb2d_pending     (pending),
      .wb2rf_rd_we0     (o_we[0]),
      .wb2rf_rd_we1     (o_we[1]),
      .wb2rf_rd_we2     (o_we[2]),
      .wb2rf_rd_we3     (o_we[3]),
      .wb2rf_pred_we0   (o_pwe[0]),
      .wb2rf_pred_we1   (o_pwe[1]),
      .wb2rf_pred_we2   (o_pwe[2]),
      .wb2rf_pred_we3   (o_pwe[3]),
      .wb2rf_rd_num0    (o_num[0]),
      .wb2rf_rd_num1    (o_num[1]),
      .wb2rf_rd_num2    (o_num[2]),
      .wb2rf_rd_num3    (o_num[3]),
      .wb2rf_rd_data0   (o_data[0]),
      .wb2rf_rd_data1   (o_data[1]),
      .wb2rf_rd_data2   (o_data[2]),
      .wb2rf_rd_data3   (o_data[3]),
      .wb2d_fifo_count  (cnt)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      else passed++;
   endtask

   // Advance the model by one edge from the inputs currently driven.
   task automatic model_step();
      int   sz;
      int   sel;
      ent_t h;
      sz  = q.size();
      sel = -1;
      if (rst) begin
         q.delete();
         m_pend = '0;
         for (int i = 0; i < 4; i++) begin
            e_we[i] = 1'b0; e_pwe[i] = 1'b0; e_num[i] = '0; e_data[i] = '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            e_we[i]   = rd_we[i];
            e_pwe[i]  = pred_we[i];
            e_num[i]  = rd_num[5*i +: 5];
            e_data[i] = rd_data[32*i +: 32];
         end
         for (int i = 3; i >= 0; i--)
            if (sel < 0 && !rd_we[i] && !pred_we[i]) sel = i;
         if (sz > 0 && sel >= 0) begin
            h = q.pop_front();
            e_we[sel] = 1'b1; e_pwe[sel] = 1'b0; e_num[sel] = h.n; e_data[sel] = h.d;
            m_pend[h.n] = 1'b0;
         end
         if (valid && sz < D) q.push_back('{n: mnum, d: mdata});
         if (issue) m_pend[inum] = 1'b1;
      end
   endtask

   task automatic tick();
      #1;
      chk("ready", 32'(ready), 32'(!rst && q.size() < D));
      model_step();
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rd_we%0d", i),   32'(o_we[i]),  32'(e_we[i]));
         chk($sformatf("pred_we%0d", i), 32'(o_pwe[i]), 32'(e_pwe[i]));
         chk($sformatf("rd_num%0d", i),  32'(o_num[i]), 32'(e_num[i]));
         chk($sformatf("rd_data%0d", i), o_data[i],     e_data[i]);
      end
      chk("pending", pending, m_pend);
      chk("count", 32'(cnt), 32'(q.size()));
   endtask

   task automatic lanes(input logic [3:0] we, input logic [3:0] pwe);
      rd_we   = we;
      pred_we = pwe;
      rd_num  = {$urandom, $urandom} & 64'hFFFFF;
      rd_data = {$urandom, $urandom, $urandom, $urandom};
   endtask

   initial begin
      rst = 1'b1; valid = 1'b0; mnum = '0; mdata = '0; issue = 1'b0; inum = '0;
      rd_we = '0; pred_we = '0; rd_num = '0; rd_data = '0;
      m_pend = '0;
      for (int i = 0; i < 4; i++) begin
         e_we[i] = 1'b0; e_pwe[i] = 1'b0; e_num[i] = '0; e_data[i] = '0;
      end
      tick(); tick();
      chk("rst_we0", 32'(o_we[0]), 32'd0);
      chk("rst_count", 32'(cnt), 32'd0);
      chk("rst_ready", 32'(ready), 32'd0);
      rst = 1'b0;

      // pass-through
      rd_we = 4'hF; pred_we = 4'h0;
      rd_num  = {5'd4, 5'd3, 5'd2, 5'd1};
      rd_data = {32'h44, 32'h33, 32'h22, 32'h11};
      tick();
      chk("pt_num0", 32'(o_num[0]), 32'd1);
      chk("pt_we2", 32'(o_we[2]), 32'd1);
      chk("pt_data3", o_data[3], 32'h44);
      chk("pt_count", 32'(cnt), 32'd0);

      // insertion into highest free lane
      lanes(4'hF, 4'h0); issue = 1'b1; inum = 5'd9;
      tick();
      issue = 1'b0;
      chk("ins_pend_set", 32'(pending[9]), 32'd1);
      valid = 1'b1; mnum = 5'd9; mdata = 32'hDEADBEEF;
      tick();
      valid = 1'b0;
      lanes(4'b0101, 4'h0);
      tick();
      chk("ins_we3", 32'(o_we[3]), 32'd1);
      chk("ins_num3", 32'(o_num[3]), 32'd9);
      chk("ins_data3", o_data[3], 32'hDEADBEEF);
      chk("ins_we1", 32'(o_we[1]), 32'd0);
      chk("ins_pend_clr", 32'(pending[9]), 32'd0);

      // no free lane
      lanes(4'hF, 4'h0); valid = 1'b1;
      for (int k = 0; k < 2; k++) begin
         mnum = 5'($urandom); mdata = $urandom;
         tick();
      end
      valid = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      chk("nofree_count", 32'(cnt), 32'd2);
      lanes(4'b1011, 4'h0);
      tick();
      chk("nofree_we2", 32'(o_we[2]), 32'd1);
      chk("nofree_count1", 32'(cnt), 32'd1);
      lanes(4'h0, 4'h0);
      tick();

      // full FIFO, ignored push, wrap
      lanes(4'hF, 4'h0); valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         mnum = 5'($urandom); mdata = $urandom;
         tick();
      end
      chk("full_count", 32'(cnt), 32'd4);
      mdata = 32'hBADBAD00;
      tick();
      lanes(4'b0111, 4'h0);
      #1 chk("full_ready_pop", 32'(ready), 32'd0);
      tick();
      for (int k = 0; k < 10; k++) begin
         lanes(4'b1110, 4'h0); mnum = 5'($urandom); mdata = $urandom;
         tick();
      end
      valid = 1'b0;
      lanes(4'h0, 4'h0);
      for (int k = 0; k < 5; k++) tick();

      // scoreboard conflict
      lanes(4'hF, 4'h0); issue = 1'b1; inum = 5'd5; valid = 1'b1; mnum = 5'd5; mdata = $urandom;
      tick();
      valid = 1'b0;
      lanes(4'b1110, 4'h0);
      tick();
      issue = 1'b0;
      chk("conflict_pend5", 32'(pending[5]), 32'd1);

      // mid-operation reset
      lanes(4'hF, 4'h0); issue = 1'b1; inum = 5'd9;
      tick();
      issue = 1'b0;
      chk("pre_rst_pend", pending, 32'h0000_0220);
      valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         mnum = 5'(7 + k); mdata = $urandom;
         tick();
      end
      valid = 1'b0;
      chk("pre_rst_count", 32'(cnt), 32'd3);
      rst = 1'b1;
      tick();
      chk("mid_rst_count", 32'(cnt), 32'd0);
      chk("mid_rst_pend", pending, 32'd0);
      chk("mid_rst_we3", 32'(o_we[3]), 32'd0);
      rst = 1'b0;
      lanes(4'h0, 4'h0);
      #1 chk("post_rst_ready", 32'(ready), 32'd1);
      for (int k = 0; k < 6; k++) tick();

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         rst = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 3) == 0) lanes(4'hF, 4'($urandom));
         else lanes(4'($urandom), 4'($urandom & $urandom));
         valid = ($urandom_range(0, 2) != 0);
         mnum  = 5'($urandom);
         mdata = $urandom;
         issue = ($urandom_range(0, 2) == 0);
         inum  = 5'($urandom);
         tick();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
